// File: rtl/pool_apb_initiator.sv
// APB master that runs one pool pass per accepted command: program Flen/num_INCH, pulse START, poll DONE, read clk_counter.
// Optional macro POLL_TIMEOUT_EN bounds DONE polling to POLL_MAX reads and reports err when the budget runs out.
module pool_apb_initiator #(
  parameter logic [31:0] ADDR_START  = 32'h00,
  parameter logic [31:0] ADDR_DONE   = 32'h04,
  parameter logic [31:0] ADDR_FLEN   = 32'h08,
  parameter logic [31:0] ADDR_INCH   = 32'h0C,
  parameter logic [31:0] ADDR_CLKCNT = 32'h10,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned POLL_MAX    = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_flen,
  input  logic [8:0]  cmd_inch,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cycles,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_FLEN, S_WR_INCH, S_WR_START, S_POLL, S_GAP, S_WR_STOP, S_RD_CNT, S_FIN
  } state_t;

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t        state_q, state_d;
  logic          access_q, access_d;
  logic [5:0]    flen_q, flen_d;
  logic [8:0]    inch_q, inch_d;
  logic          err_q, err_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [GW-1:0] gap_q, gap_d;

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  logic [PW-1:0] poll_q, poll_d;
  logic          tmo_q, tmo_d;
`else
  logic unused_poll_max;
  assign unused_poll_max = |POLL_MAX;
`endif

  logic        sel;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  // Address/data are pure decodes of the registered state, so they hold from SETUP through ACCESS.
  always_comb begin
    sel    = 1'b1;
    paddr  = '0;
    pwrite = 1'b0;
    pwdata = '0;
    case (state_q)
      S_WR_FLEN:  begin paddr = ADDR_FLEN;  pwrite = 1'b1; pwdata = {26'b0, flen_q}; end
      S_WR_INCH:  begin paddr = ADDR_INCH;  pwrite = 1'b1; pwdata = {23'b0, inch_q}; end
      S_WR_START: begin paddr = ADDR_START; pwrite = 1'b1; pwdata = 32'd1; end
      S_POLL:     paddr = ADDR_DONE;
      S_WR_STOP:  begin paddr = ADDR_START; pwrite = 1'b1; end
      S_RD_CNT:   paddr = ADDR_CLKCNT;
      default:    sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    flen_d   = flen_q;
    inch_d   = inch_q;
    err_d    = err_q;
    cycles_d = cycles_q;
    gap_d    = gap_q;
`ifdef POLL_TIMEOUT_EN
    poll_d   = poll_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_WR_FLEN;
          access_d = 1'b0;
          flen_d   = cmd_flen;
          inch_d   = cmd_inch;
          err_d    = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_POLL;
        else                   gap_d   = gap_q + GW'(1);
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!access_q) begin
          access_d = 1'b1;
        end else if (PREADY) begin
          access_d = 1'b0;
          if (PSLVERR) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else begin
            case (state_q)
              S_WR_FLEN: state_d = S_WR_INCH;
              S_WR_INCH: begin
                state_d = S_WR_START;
`ifdef POLL_TIMEOUT_EN
                poll_d  = '0;
                tmo_d   = 1'b0;
`endif
              end
              S_WR_START: state_d = S_POLL;
              S_POLL: begin
                if (PRDATA[0]) begin
                  state_d = S_WR_STOP;
`ifdef POLL_TIMEOUT_EN
                end else if (poll_q == POLL_LAST) begin
                  state_d = S_WR_STOP;
                  tmo_d   = 1'b1;
`endif
                end else if (POLL_GAP == 0) begin
                  state_d = S_POLL;
                end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
                end
`ifdef POLL_TIMEOUT_EN
                poll_d = poll_q + PW'(1);
`endif
              end
              S_WR_STOP: begin
`ifdef POLL_TIMEOUT_EN
                // A timed-out run never reads the counter; cycles keeps its old value.
                if (tmo_q) begin
                  state_d = S_FIN;
                  err_d   = 1'b1;
                end else begin
                  state_d = S_RD_CNT;
                end
`else
                state_d = S_RD_CNT;
`endif
              end
              S_RD_CNT: begin
                cycles_d = PRDATA;
                state_d  = S_FIN;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      access_q <= 1'b0;
      flen_q   <= '0;
      inch_q   <= '0;
      err_q    <= 1'b0;
      cycles_q <= '0;
      gap_q    <= '0;
`ifdef POLL_TIMEOUT_EN
      poll_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      flen_q   <= flen_d;
      inch_q   <= inch_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
      gap_q    <= gap_d;
`ifdef POLL_TIMEOUT_EN
      poll_q   <= poll_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;
  assign cycles    = cycles_q;
  assign PSEL      = sel;
  assign PENABLE   = access_q;
  assign PADDR     = paddr;
  assign PWRITE    = pwrite;
  assign PWDATA    = pwdata;

endmodule
